uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port RxD  input  1  asynchronous serial line, idle high.
REQ-005 Port data  output  8  last correctly framed received byte.
REQ-006 Port valid  output  1  one-cycle pulse: data holds a new byte.
REQ-007 Port framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 Port busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-009 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, no parity.
REQ-010 RxD SHALL pass through a 2-flop synchronizer (rx_s) plus a history flop (rx_p); all decisions use rx_s only.
REQ-011 A 16-bit bit-timing counter and 3-bit data-bit index SHALL be used; counter clears on every state transition.
REQ-012 FSM states: IDLE, START, DATA, STOP.
REQ-013 IDLE: on rx_p==1 and rx_s==0 (falling edge) -> START, counter=0; a line held low SHALL NOT start a frame.
REQ-014 START: when counter reaches CLKS_PER_BIT/2-1 (integer divide), sample rx_s; 0 -> DATA, index=0; 1 -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: when counter reaches CLKS_PER_BIT-1, shift rx_s into bit[index] of the internal shift register; index 7 -> STOP, else index+1.
REQ-016 STOP: when counter reaches CLKS_PER_BIT-1, sample rx_s; 1 -> data<=shift register, valid=1 for one cycle; 0 -> framing_error=1 for one cycle, data unchanged; both cases -> IDLE.
REQ-017 All samples SHALL therefore occur at bit mid-points; valid/framing_error rise in the clock cycle after the mid-stop sample edge.
REQ-018 valid and framing_error SHALL never be asserted simultaneously, and each SHALL be 0 on every cycle except the single-cycle pulse.
REQ-019 data SHALL hold its value between valid pulses.
REQ-020 Back-to-back frames: a start edge arriving any time after return to IDLE SHALL be accepted; no extra idle bits required beyond the half stop bit remaining.
REQ-021 After a framing error with line still low (break), no new frame SHALL start until RxD returns high and falls again.
REQ-022 RxD changes mid-bit away from the sample point SHALL not affect the received value.

Reset
REQ-023 While reset is high at a clk edge: state=IDLE, counter=0, index=0, shift register=0, data=8'h00, valid=0, framing_error=0, busy=0, synchronizer and history flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame without any valid or framing_error pulse; reception resumes on the next falling edge after reset deasserts.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-025 Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit -> exactly one valid pulse, data=0xA5, framing_error stays 0, busy high from start detect until return to IDLE.
REQ-026 Send 0x3C then 0xFF back-to-back with one stop bit each -> two valid pulses, data 0x3C then 0xFF, no framing_error.
REQ-027 Low glitch of 4 clk on idle line -> no valid, no framing_error, busy returns to 0 within 8+3 clk of the glitch start.
REQ-028 Send 0x55 with stop bit driven 0, then hold RxD low 40 bit times -> one framing_error pulse, data unchanged from prior value, no further activity until RxD rises and falls.
REQ-029 Assert reset for 1 clk during data bit 4 of a 0x81 frame -> no pulses, all outputs at reset values; next frame 0x81 -> valid with data=0x81.
REQ-030 Default CLKS_PER_BIT=868, send 0x0F at 868 clk/bit with ±2% bit-period skew -> data=0x0F, valid pulse, no framing_error.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing error detection
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      next_state;
    logic        rx_m;
    logic        rx_s;
    logic        rx_p;
    logic [15:0] count;
    logic [2:0]  index;
    logic [7:0]  shift;
    logic        half_hit;
    logic        full_hit;
    logic        sample_data;
    logic        stop_ok;
    logic        stop_bad;

    assign half_hit = (count == HALF_LAST);
    assign full_hit = (count == FULL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            rx_p          <= 1'b1;
            count         <= 16'd0;
            index         <= 3'd0;
            shift         <= 8'h00;
            data          <= 8'h00;
            valid         <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_m  <= RxD;
            rx_s  <= rx_m;
            rx_p  <= rx_s;
            state <= next_state;
            // The counter restarts at every state change and at each data-bit boundary.
            if (next_state != state || sample_data) begin
                count <= 16'd0;
            end else if (state != IDLE) begin
                count <= count + 16'd1;
            end else begin
                count <= 16'd0;
            end
            if (state == START && next_state == DATA) begin
                index <= 3'd0;
            end else if (sample_data) begin
                index <= index + 3'd1;
            end
            if (sample_data) begin
                shift[index] <= rx_s;
            end
            if (stop_ok) begin
                data <= shift;
            end
            valid         <= stop_ok;
            framing_error <= stop_bad;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (rx_p && !rx_s) next_state = START;
            START: if (half_hit) next_state = rx_s ? IDLE : DATA;
            DATA:  if (full_hit && index == 3'd7) next_state = STOP;
            STOP:  if (full_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        sample_data = (state == DATA) && full_hit;
        stop_ok     = (state == STOP) && full_hit && rx_s;
        stop_bad    = (state == STOP) && full_hit && !rx_s;
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int CPB      = 16;
    localparam int CPB_SLOW = 868;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       rxd_slow;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;
    logic [7:0] slow_data;
    logic       slow_valid;
    logic       slow_fe;
    logic       slow_busy;

    int checks;
    int errors;
    int busy_cycles;

    logic [7:0] model_data;
    logic [7:0] slow_model_data;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [8:0] slow_exp_q[$];
    logic [8:0] slow_got_q[$];

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .RxD(rxd), .data(data),
        .valid(valid), .framing_error(framing_error), .busy(busy)
    );

    uart_receiver dut_slow (
        .clk(clk), .reset(reset), .RxD(rxd_slow), .data(slow_data),
        .valid(slow_valid), .framing_error(slow_fe), .busy(slow_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Received events are {framing_error, data} as seen on a pulse cycle.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (valid || framing_error) begin
            check("exclusive_pulse", {31'd0, valid && framing_error}, 32'd0);
            got_q.push_back({framing_error, data});
        end
        if (slow_valid || slow_fe) slow_got_q.push_back({slow_fe, slow_data});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rxd = v;
        else rxd_slow = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit,
                              input int cpb, input bit jitter);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (which == 0) begin
            if (stop_bit) begin
                exp_q.push_back({1'b0, b});
                model_data = b;
            end else begin
                exp_q.push_back({1'b1, model_data});
            end
        end else begin
            if (stop_bit) begin
                slow_exp_q.push_back({1'b0, b});
                slow_model_data = b;
            end else begin
                slow_exp_q.push_back({1'b1, slow_model_data});
            end
        end
        for (int i = 0; i < 10; i++) begin
            set_line(which, bits[i]);
            // A one-cycle spike late in a data bit must not disturb the mid-bit sample.
            if (jitter && i >= 1 && i <= 8 && $urandom_range(0, 1) == 1) begin
                tick(13);
                set_line(which, ~bits[i]);
                tick(1);
                set_line(which, bits[i]);
                tick(cpb - 14);
            end else begin
                tick(cpb);
            end
        end
    endtask

    task automatic compare_events(input string tag, input int which);
        if (which == 0) begin
            check({tag, "_count"}, got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check(tag, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
            exp_q.delete();
            got_q.delete();
        end else begin
            check({tag, "_count"}, slow_got_q.size(), slow_exp_q.size());
            for (int i = 0; i < slow_exp_q.size() && i < slow_got_q.size(); i++)
                check(tag, {23'd0, slow_got_q[i]}, {23'd0, slow_exp_q[i]});
            slow_exp_q.delete();
            slow_got_q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic [7:0] b;
        logic       stop_bit;
        logic       prev_bad;

        checks          = 0;
        errors          = 0;
        busy_cycles     = 0;
        model_data      = 8'h00;
        slow_model_data = 8'h00;
        reset           = 1'b1;
        rxd             = 1'b1;
        rxd_slow        = 1'b1;
        tick(3);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_fe", {31'd0, framing_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(5);

        // Single frame: busy spans half start bit + 8 data bits + stop sample point.
        b0 = busy_cycles;
        send_frame(0, 8'hA5, 1'b1, CPB, 1'b0);
        tick(4);
        compare_events("a5", 0);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_busy_cycles", busy_cycles - b0, CPB / 2 + 9 * CPB);
        check("a5_idle", {31'd0, busy}, 32'd0);

        b0 = busy_cycles;
        send_frame(0, 8'h3C, 1'b1, CPB, 1'b0);
        send_frame(0, 8'hFF, 1'b1, CPB, 1'b0);
        tick(4);
        compare_events("b2b", 0);
        check("b2b_busy_cycles", busy_cycles - b0, 2 * (CPB / 2 + 9 * CPB));

        b0 = busy_cycles;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(7);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_seen", {31'd0, (busy_cycles - b0) > 0}, 32'd1);
        tick(CPB);
        compare_events("glitch", 0);

        send_frame(0, 8'h55, 1'b0, CPB, 1'b0);
        compare_events("fe", 0);
        check("fe_data_kept", {24'd0, data}, {24'd0, model_data});
        b0 = busy_cycles;
        tick(40 * CPB);
        check("break_quiet", busy_cycles - b0, 32'd0);
        compare_events("break", 0);
        rxd = 1'b1;
        tick(CPB);
        send_frame(0, 8'h12, 1'b1, CPB, 1'b0);
        tick(4);
        compare_events("after_break", 0);

        // Abort 0x81 halfway through data bit 4; the sender abandons the line too.
        b = 8'h81;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = b[4];
        tick(CPB / 2);
        reset = 1'b1;
        rxd = 1'b1;
        tick(1);
        reset = 1'b0;
        model_data = 8'h00;
        check("abort_data", {24'd0, data}, 32'h00);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_fe", {31'd0, framing_error}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        tick(12 * CPB);
        compare_events("abort", 0);
        send_frame(0, 8'h81, 1'b1, CPB, 1'b0);
        tick(4);
        compare_events("after_abort", 0);
        check("after_abort_data", {24'd0, data}, 32'h81);

        prev_bad = 1'b0;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            rxd = 1'b1;
            if (prev_bad) tick(CPB + $urandom_range(0, 20));
            else tick($urandom_range(0, 20));
            send_frame(0, b, stop_bit, CPB, 1'b1);
            prev_bad = !stop_bit;
        end
        rxd = 1'b1;
        tick(2 * CPB);
        compare_events("random", 0);
        check("random_data", {24'd0, data}, {24'd0, model_data});

        send_frame(1, 8'h0F, 1'b1, CPB_SLOW + CPB_SLOW / 50, 1'b0);
        rxd_slow = 1'b1;
        tick(CPB_SLOW);
        send_frame(1, 8'h0F, 1'b1, CPB_SLOW - CPB_SLOW / 50, 1'b0);
        rxd_slow = 1'b1;
        tick(CPB_SLOW);
        compare_events("slow", 1);
        check("slow_data", {24'd0, slow_data}, 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
